// File: rtl/ap_line_sequencer.sv
// ap_line_sequencer: execute stage sitting directly upstream of the AP/data line.
// Takes one opcode per handshake (with a repeat count), turns move opcodes into
// single-cycle ApRequest/DataRequest pulses paced by the line's Ready, resolves
// loop brackets from DataZero and reports completion with Done/BranchTaken.
// Optional build macro AP_BOUNDS_CHECK_EN: when defined, a LEFT step issued while
// ApZero=1 is suppressed and flags Error instead of letting the line wrap.
module ap_line_sequencer #(
  parameter int RPT_W   = 4,
  parameter int TIMEOUT = 1023,
  parameter int TO_W    = 10
) (
  input  logic             Clk,
  input  logic             Rst_n,
  input  logic [2:0]       Insn,
  input  logic [RPT_W-1:0] Repeat,
  input  logic             InsnValid,
  output logic             InsnReady,
  output logic             ApRequest,
  output logic             DataRequest,
  output logic             Dec,
  input  logic             LineReady,
  input  logic             DataZero,
  input  logic             ApZero,
  output logic             Done,
  output logic             BranchTaken,
  output logic             Error
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    EVAL  = 2'd3
  } state_t;

  localparam logic [2:0] OP_NOP        = 3'd0;
  localparam logic [2:0] OP_INC        = 3'd1;
  localparam logic [2:0] OP_DEC        = 3'd2;
  localparam logic [2:0] OP_RIGHT      = 3'd3;
  localparam logic [2:0] OP_LEFT       = 3'd4;
  localparam logic [2:0] OP_LOOP_BEGIN = 3'd5;
  localparam logic [2:0] OP_LOOP_END   = 3'd6;

  // Timeout compare value: WAIT has lasted TIMEOUT cycles when the counter
  // (cleared in ISSUE, counting every non-completing WAIT cycle) reaches TIMEOUT-1.
  localparam bit             TO_EN   = (TIMEOUT != 0);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);
  localparam logic [RPT_W-1:0] RPT_ONE = {{(RPT_W-1){1'b0}}, 1'b1};

  state_t           state;
  logic             kind_ap;     // 1: address-pointer step, 0: data-cell step
  logic             dec;
  logic [RPT_W-1:0] rem;
  logic [TO_W-1:0]  to_cnt;
  logic             first_wait;  // first WAIT cycle, where LineReady is meaningless
  logic             eval_end;    // bracket being evaluated is LOOP_END
  logic             done;
  logic             branch;
  logic             error;

  logic             accept;
  logic             line_go;
  logic             timeout_hit;
  logic             step_blocked;
  logic [RPT_W-1:0] rpt_load;

  assign InsnReady   = (state == IDLE) & LineReady & ~error;
  assign accept      = InsnValid & InsnReady;
  assign rpt_load    = (Repeat == '0) ? RPT_ONE : Repeat;
  assign line_go     = ~first_wait & LineReady;
  assign timeout_hit = TO_EN && (to_cnt == TO_LAST);

`ifdef AP_BOUNDS_CHECK_EN
  // A LEFT step from address 0 would underflow the pointer: refuse it.
  assign step_blocked = (state == ISSUE) & kind_ap & dec & ApZero;
`else
  // No bound checking: LEFT at address 0 is forwarded and the line wraps.
  logic unused_ap_zero;
  assign unused_ap_zero = ApZero;
  assign step_blocked   = 1'b0;
`endif

  // Requests are a decode of the ISSUE state, so each one lasts exactly one cycle.
  assign ApRequest   = (state == ISSUE) & kind_ap & ~step_blocked;
  assign DataRequest = (state == ISSUE) & ~kind_ap;
  assign Dec         = dec;
  assign Done        = done;
  assign BranchTaken = branch;
  assign Error       = error;

  // Sequencer state machine with registered Done/BranchTaken/Dec/Error.
  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      state      <= IDLE;
      kind_ap    <= 1'b0;
      dec        <= 1'b0;
      rem        <= '0;
      to_cnt     <= '0;
      first_wait <= 1'b0;
      eval_end   <= 1'b0;
      done       <= 1'b0;
      branch     <= 1'b0;
      error      <= 1'b0;
    end else begin
      done   <= 1'b0;
      branch <= 1'b0;
      case (state)
        IDLE: begin
          // Dec stays valid through the Done cycle, then drops here.
          dec <= 1'b0;
          if (accept) begin
            case (Insn)
              OP_INC, OP_DEC, OP_RIGHT, OP_LEFT: begin
                kind_ap <= (Insn == OP_RIGHT) || (Insn == OP_LEFT);
                dec     <= (Insn == OP_DEC) || (Insn == OP_LEFT);
                rem     <= rpt_load;
                state   <= ISSUE;
              end
              OP_LOOP_BEGIN, OP_LOOP_END: begin
                eval_end <= (Insn == OP_LOOP_END);
                state    <= EVAL;
              end
              OP_NOP: begin
                done <= 1'b1;
              end
              default: begin
                error <= 1'b1;
              end
            endcase
          end
        end

        ISSUE: begin
          if (step_blocked) begin
            // Suppressed step: remaining repeats are dropped and no Done follows.
            error <= 1'b1;
            rem   <= '0;
            dec   <= 1'b0;
            state <= IDLE;
          end else begin
            rem        <= rem - RPT_ONE;
            to_cnt     <= '0;
            first_wait <= 1'b1;
            state      <= WAIT;
          end
        end

        WAIT: begin
          first_wait <= 1'b0;
          if (line_go) begin
            if (rem != '0) begin
              state <= ISSUE;
            end else begin
              done  <= 1'b1;
              state <= IDLE;
            end
          end else if (timeout_hit) begin
            error <= 1'b1;
            dec   <= 1'b0;
            state <= IDLE;
          end else if (TO_EN) begin
            to_cnt <= to_cnt + TO_W'(1);
          end
        end

        EVAL: begin
          // [ jumps forward on zero, ] jumps back on non-zero.
          branch <= eval_end ? ~DataZero : DataZero;
          done   <= 1'b1;
          state  <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ap_line_sequencer.sv
// tb_ap_line_sequencer: directed stimulus with a scoreboard queue. The stimulus
// pushes the expected completion of each instruction; a monitor pops and checks
// whenever the DUT presents Done or a fresh Error. A small line model drops
// Ready while a request is high and returns it LINE_DLY cycles later.
module tb_ap_line_sequencer;

  localparam int RPT_W    = 4;
  localparam int TIMEOUT  = 8;
  localparam int LINE_DLY = 1;

  logic             Clk = 1'b0;
  logic             Rst_n = 1'b0;
  logic [2:0]       Insn = 3'd0;
  logic [RPT_W-1:0] Repeat = '0;
  logic             InsnValid = 1'b0;
  logic             InsnReady;
  logic             ApRequest;
  logic             DataRequest;
  logic             Dec;
  logic             LineReady;
  logic             DataZero = 1'b0;
  logic             ApZero = 1'b0;
  logic             Done;
  logic             BranchTaken;
  logic             Error;

  ap_line_sequencer #(
    .RPT_W  (RPT_W),
    .TIMEOUT(TIMEOUT),
    .TO_W   (10)
  ) dut (
    .Clk        (Clk),
    .Rst_n      (Rst_n),
    .Insn       (Insn),
    .Repeat     (Repeat),
    .InsnValid  (InsnValid),
    .InsnReady  (InsnReady),
    .ApRequest  (ApRequest),
    .DataRequest(DataRequest),
    .Dec        (Dec),
    .LineReady  (LineReady),
    .DataZero   (DataZero),
    .ApZero     (ApZero),
    .Done       (Done),
    .BranchTaken(BranchTaken),
    .Error      (Error)
  );

  always #5 Clk = ~Clk;

  // Line model
  logic line_en = 1'b0;
  int   busy = 0;
  always @(posedge Clk) begin
    if (!Rst_n) busy <= 0;
    else if (ApRequest || DataRequest) busy <= LINE_DLY;
    else if (busy != 0) busy <= busy - 1;
  end
  assign LineReady = line_en && (busy == 0) && !(ApRequest || DataRequest);

  int cyc = 0;
  always @(posedge Clk) cyc <= cyc + 1;

  typedef struct {
    bit is_err;
    bit branch;
    int n_data;
    int n_ap;
    bit dec;
    int lat;   // edges from accept to the event, -1 = not checked
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;

  function automatic exp_t mk(bit is_err, bit br, int nd, int na, bit d, int lat);
    exp_t e;
    e.is_err = is_err; e.branch = br; e.n_data = nd; e.n_ap = na; e.dec = d; e.lat = lat;
    return e;
  endfunction

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, req, $time);
    end
  endtask

  // Monitor: counts pulses and checks every completion against the queue head
  initial begin
    int   n_data, n_ap, acc_cyc;
    bit   dec_bad, err_prev;
    exp_t e;
    n_data = 0; n_ap = 0; acc_cyc = 0; dec_bad = 0; err_prev = 0;
    forever begin
      @(negedge Clk);
      if (!Rst_n) begin
        n_data = 0; n_ap = 0; dec_bad = 0; err_prev = 0;
      end else begin
        if (DataRequest) n_data++;
        if (ApRequest) n_ap++;
        if ((ApRequest || DataRequest) && sb.size() > 0 && Dec !== sb[0].dec) dec_bad = 1;
        if (Done || (Error && !err_prev)) begin
          if (sb.size() == 0) begin
            chk("unexpected_event", {30'd0, Done, Error}, 0);
          end else begin
            e = sb.pop_front();
            $display("event done=%0d err=%0d br=%0d data=%0d ap=%0d lat=%0d",
                     Done, Error, BranchTaken, n_data, n_ap, cyc - acc_cyc);
            chk("event_is_error", (Done ? 0 : 1), e.is_err);
            chk("data_pulses", n_data, e.n_data);
            chk("ap_pulses", n_ap, e.n_ap);
            if (e.lat >= 0) chk("latency", cyc - acc_cyc, e.lat);
            if (Done) begin
              chk("branch", BranchTaken, e.branch);
              chk("error_low_on_done", Error, 0);
              chk("dec_at_done", Dec, e.dec);
              chk("dec_during_pulses", dec_bad, 0);
            end
          end
          n_data = 0; n_ap = 0; dec_bad = 0;
        end
        err_prev = Error;
        if (InsnValid && InsnReady) acc_cyc = cyc + 1;
      end
    end
  end

  task automatic chk_zero(input string tag);
    chk({tag, "_ap"}, ApRequest, 0);
    chk({tag, "_data"}, DataRequest, 0);
    chk({tag, "_dec"}, Dec, 0);
    chk({tag, "_done"}, Done, 0);
    chk({tag, "_branch"}, BranchTaken, 0);
    chk({tag, "_error"}, Error, 0);
    chk({tag, "_ready"}, InsnReady, 0);
  endtask

  // Hold reset 3 cycles with the line not ready, check outputs, release
  task automatic reset_dut();
    Rst_n = 1'b0; line_en = 1'b0; ApZero = 1'b0; DataZero = 1'b0; InsnValid = 1'b0;
    repeat (3) @(posedge Clk);
    @(negedge Clk);
    chk_zero("reset");
    @(posedge Clk); #1;
    Rst_n = 1'b1; line_en = 1'b1;
    @(negedge Clk);
    chk("ready_after_reset", InsnReady, 1);
    @(posedge Clk); #1;
  endtask

  // Present one instruction until accepted; called at #1 after a rising edge
  task automatic send(input logic [2:0] op, input int rep, input bit push, input exp_t e);
    int n;
    if (push) sb.push_back(e);
    Insn = op; Repeat = RPT_W'(rep); InsnValid = 1'b1;
    n = 0;
    do begin
      @(negedge Clk);
      n++;
    end while (!InsnReady && n < 200);
    if (!InsnReady) chk("accept_timeout", 0, 1);
    @(posedge Clk); #1;
    InsnValid = 1'b0;
  endtask

  // Wait for all expected completions, bounded
  task automatic drain(input int budget);
    int n;
    n = 0;
    while (sb.size() != 0 && n < budget) begin
      @(negedge Clk);
      n++;
    end
    chk("drain_pending", sb.size(), 0);
    sb.delete();
    @(posedge Clk); #1;
  endtask

  initial begin
    reset_dut();

    // INC x3: three data pulses, Dec=0
    send(3'd1, 3, 1, mk(0, 0, 3, 0, 0, 9));
    drain(60);
    // LEFT with Repeat=0 acts as one step, Dec=1
    send(3'd4, 0, 1, mk(0, 0, 0, 1, 1, 3));
    drain(60);
    // Bracket evaluation
    DataZero = 1'b1;
    send(3'd5, 0, 1, mk(0, 1, 0, 0, 0, 1));
    drain(20);
    send(3'd6, 0, 1, mk(0, 0, 0, 0, 0, 1));
    drain(20);
    DataZero = 1'b0;
    send(3'd6, 0, 1, mk(0, 1, 0, 0, 0, 1));
    drain(20);
    send(3'd5, 0, 1, mk(0, 0, 0, 0, 0, 1));
    drain(20);
    // Back-to-back NOPs
    send(3'd0, 0, 1, mk(0, 0, 0, 0, 0, 0));
    send(3'd0, 0, 1, mk(0, 0, 0, 0, 0, 0));
    drain(20);
    // DEC x2 then RIGHT at maximum repeat
    send(3'd2, 2, 1, mk(0, 0, 2, 0, 1, 6));
    drain(60);
    send(3'd3, 15, 1, mk(0, 0, 0, 15, 0, 45));
    drain(200);

    // Valid while the line is not ready: held off
    line_en = 1'b0;
    sb.push_back(mk(0, 0, 0, 0, 0, 0));
    Insn = 3'd0; InsnValid = 1'b1;
    repeat (4) begin
      @(negedge Clk);
      chk("held_off_ready", InsnReady, 0);
    end
    @(posedge Clk); #1;
    line_en = 1'b1;
    @(negedge Clk);
    @(posedge Clk); #1;
    InsnValid = 1'b0;
    drain(20);

    // LEFT x2 from address 0
    ApZero = 1'b1;
`ifdef AP_BOUNDS_CHECK_EN
    send(3'd4, 2, 1, mk(1, 0, 0, 0, 1, 1));
    drain(40);
    ApZero = 1'b0;
    reset_dut();
`else
    send(3'd4, 2, 1, mk(0, 0, 0, 2, 1, 6));
    drain(40);
    ApZero = 1'b0;
`endif

    // Reset in the middle of WAIT: nothing completes afterwards
    send(3'd1, 2, 0, mk(0, 0, 0, 0, 0, -1));
    line_en = 1'b0;
    @(posedge Clk);
    @(posedge Clk); #1;
    Rst_n = 1'b0;
    @(posedge Clk);
    @(negedge Clk);
    chk_zero("midwait_reset");
    reset_dut();
    repeat (10) @(posedge Clk);
    #1;

    // Timeout: line never returns Ready after the DEC pulse
    send(3'd2, 1, 1, mk(1, 0, 1, 0, 1, 9));
    line_en = 1'b0;
    drain(40);
    line_en = 1'b1;
    @(negedge Clk);
    chk("ready_after_timeout", InsnReady, 0);
    chk("error_sticky_timeout", Error, 1);
    reset_dut();

    // Illegal opcode
    send(3'd7, 0, 1, mk(1, 0, 0, 0, 0, 0));
    drain(20);
    repeat (5) @(posedge Clk);
    @(negedge Clk);
    chk("ready_after_illegal", InsnReady, 0);
    chk("error_sticky_illegal", Error, 1);
    chk("done_low_after_illegal", Done, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Global run bound
  initial begin
    #500000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "run bound exceeded");
  end

endmodule
